// File: rtl/noc_config_filereg_bridge.sv
// Per-tile NoC configuration endpoint: executes request packets as single
// file-register writes/reads and returns an ack or read-data response.
module noc_config_filereg_bridge #(
    parameter int NetworkSwitchAddressId         = 0,
    parameter int NetworkSwitchAddressIdWidth    = 4,
    parameter int NetworkFlitWidth               = 64,
    parameter int NetworkFlitTypeWidth           = 2,
    parameter int NetworkVirtualChannelIdWidth   = 1,
    parameter int NetworkNumberOfVirtualChannels = 2,
    parameter int ConfigVirtualChannel           = 0,
    parameter int FileRegAddrWidth               = 8,
    parameter int FileRegDataWidth               = 32
) (
    input  logic                                      clk_network_i,
    input  logic                                      rst_network_ni,
    input  logic                                      network_valid_i,
    input  logic [NetworkFlitWidth-1:0]               network_flit_i,
    input  logic [NetworkFlitTypeWidth-1:0]           network_flit_type_i,
    input  logic [NetworkVirtualChannelIdWidth-1:0]   network_vc_id_i,
    output logic [NetworkNumberOfVirtualChannels-1:0] network_go_o,
    output logic                                      network_valid_o,
    output logic [NetworkFlitWidth-1:0]               network_flit_o,
    output logic [NetworkFlitTypeWidth-1:0]           network_flit_type_o,
    output logic [NetworkVirtualChannelIdWidth-1:0]   network_vc_id_o,
    input  logic [NetworkNumberOfVirtualChannels-1:0] network_go_i,
    output logic                                      filereg_wr_en_o,
    output logic                                      filereg_rd_en_o,
    output logic [FileRegAddrWidth-1:0]               filereg_addr_o,
    output logic [FileRegDataWidth-1:0]               filereg_wdata_o,
    input  logic [FileRegDataWidth-1:0]               filereg_rdata_i,
    output logic [7:0]                                error_count_o
);
    localparam int AW  = FileRegAddrWidth;
    localparam int DW  = FileRegDataWidth;
    localparam int IDW = NetworkSwitchAddressIdWidth;
    localparam int FW  = NetworkFlitWidth;
    localparam int FTW = NetworkFlitTypeWidth;
    localparam int NVC = NetworkNumberOfVirtualChannels;
    localparam int VCW = NetworkVirtualChannelIdWidth;

    localparam logic [FTW-1:0] FLIT_HEADER      = FTW'(2'b00);
    localparam logic [FTW-1:0] FLIT_TAIL        = FTW'(2'b10);
    localparam logic [FTW-1:0] FLIT_HEADER_TAIL = FTW'(2'b11);
    localparam logic [IDW-1:0] OWN_ID           = IDW'(NetworkSwitchAddressId);
    localparam logic [VCW-1:0] CFG_VC           = VCW'(ConfigVirtualChannel);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_RX_DATA   = 4'd1,
        ST_DROP      = 4'd2,
        ST_REG_WRITE = 4'd3,
        ST_REG_READ  = 4'd4,
        ST_READ_WAIT = 4'd5,
        ST_TX_ACK    = 4'd6,
        ST_TX_HEADER = 4'd7,
        ST_TX_TAIL   = 4'd8
    } state_e;

    function automatic logic [FW-1:0] pack_header(input logic [IDW-1:0] dst,
                                                  input logic [IDW-1:0] src,
                                                  input logic           op,
                                                  input logic [AW-1:0]  addr);
        logic [FW-1:0] f;
        f                    = '0;
        f[AW-1:0]            = addr;
        f[AW]                = op;
        f[AW+1 +: IDW]       = src;
        f[AW+1+IDW +: IDW]   = dst;
        return f;
    endfunction

    state_e          state_q, state_d;
    logic [NVC-1:0]  go_q, go_d;
    logic            valid_q, valid_d;
    logic [FW-1:0]   flit_q, flit_d;
    logic [FTW-1:0]  flit_type_q, flit_type_d;
    logic            wr_en_q, wr_en_d;
    logic            rd_en_q, rd_en_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [AW-1:0]   req_addr_q, req_addr_d;
    logic [IDW-1:0]  req_src_q, req_src_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic            accept_s, xfer_s, err_evt_s, in_op_s, unused_s;
    logic [AW-1:0]   in_addr_s;
    logic [IDW-1:0]  in_src_s, in_dst_s;

    assign in_addr_s = network_flit_i[AW-1:0];
    assign in_op_s   = network_flit_i[AW];
    assign in_src_s  = network_flit_i[AW+1 +: IDW];
    assign in_dst_s  = network_flit_i[AW+1+IDW +: IDW];
    assign accept_s  = network_valid_i && (network_vc_id_i == CFG_VC) && go_q[ConfigVirtualChannel];
    assign xfer_s    = valid_q && network_go_i[ConfigVirtualChannel];
    assign unused_s  = ^{network_go_i, network_flit_i};

    // Request decode, register access sequencing and response generation
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        flit_d      = flit_q;
        flit_type_d = flit_type_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        req_addr_d  = req_addr_q;
        req_src_d   = req_src_q;
        err_evt_s   = 1'b0;
        go_d        = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (in_dst_s != OWN_ID) begin
                        err_evt_s = 1'b1;
                        if (network_flit_type_i == FLIT_HEADER) state_d = ST_DROP;
                        else                                    state_d = ST_IDLE;
                    end else begin
                        case (network_flit_type_i)
                            FLIT_HEADER: begin
                                if (in_op_s) begin
                                    req_addr_d = in_addr_s;
                                    req_src_d  = in_src_s;
                                    state_d    = ST_RX_DATA;
                                end else begin
                                    err_evt_s = 1'b1;
                                    state_d   = ST_DROP;
                                end
                            end
                            FLIT_HEADER_TAIL: begin
                                if (in_op_s) begin
                                    err_evt_s = 1'b1;
                                end else begin
                                    req_addr_d = in_addr_s;
                                    req_src_d  = in_src_s;
                                    addr_d     = in_addr_s;
                                    rd_en_d    = 1'b1;
                                    state_d    = ST_REG_READ;
                                end
                            end
                            default: err_evt_s = 1'b1;
                        endcase
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RX_DATA: begin
                if (accept_s) begin
                    case (network_flit_type_i)
                        FLIT_TAIL: begin
                            wr_en_d = 1'b1;
                            addr_d  = req_addr_q;
                            wdata_d = network_flit_i[DW-1:0];
                            state_d = ST_REG_WRITE;
                        end
                        FLIT_HEADER_TAIL: begin
                            err_evt_s = 1'b1;
                            state_d   = ST_IDLE;
                        end
                        default: begin
                            err_evt_s = 1'b1;
                            state_d   = ST_DROP;
                        end
                    endcase
                end else begin
                    state_d = ST_RX_DATA;
                end
            end
            ST_DROP: begin
                if (accept_s && (network_flit_type_i == FLIT_TAIL ||
                                 network_flit_type_i == FLIT_HEADER_TAIL)) state_d = ST_IDLE;
                else                                                        state_d = ST_DROP;
            end
            ST_REG_WRITE: begin
                state_d     = ST_TX_ACK;
                valid_d     = 1'b1;
                flit_d      = pack_header(req_src_q, OWN_ID, 1'b1, req_addr_q);
                flit_type_d = FLIT_HEADER_TAIL;
            end
            ST_REG_READ: state_d = ST_READ_WAIT;
            ST_READ_WAIT: begin
                rdata_d     = filereg_rdata_i;
                state_d     = ST_TX_HEADER;
                valid_d     = 1'b1;
                flit_d      = pack_header(req_src_q, OWN_ID, 1'b0, req_addr_q);
                flit_type_d = FLIT_HEADER;
            end
            ST_TX_HEADER: begin
                if (xfer_s) begin
                    state_d          = ST_TX_TAIL;
                    flit_d           = '0;
                    flit_d[DW-1:0]   = rdata_q;
                    flit_type_d      = FLIT_TAIL;
                end else begin
                    state_d = ST_TX_HEADER;
                end
            end
            ST_TX_ACK, ST_TX_TAIL: begin
                if (xfer_s) begin
                    state_d     = ST_IDLE;
                    valid_d     = 1'b0;
                    flit_d      = '0;
                    flit_type_d = '0;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // go is a registered view of whether the next state can take flits
        if (state_d == ST_IDLE || state_d == ST_RX_DATA || state_d == ST_DROP) go_d[ConfigVirtualChannel] = 1'b1;
        else                                                                    go_d[ConfigVirtualChannel] = 1'b0;
        if (err_evt_s && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
        else                                   err_cnt_d = err_cnt_q;
    end

    // State and output registers
    always_ff @(posedge clk_network_i or negedge rst_network_ni) begin
        if (!rst_network_ni) begin
            state_q     <= ST_IDLE;
            go_q        <= '0;
            valid_q     <= 1'b0;
            flit_q      <= '0;
            flit_type_q <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            req_addr_q  <= '0;
            req_src_q   <= '0;
            err_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            go_q        <= go_d;
            valid_q     <= valid_d;
            flit_q      <= flit_d;
            flit_type_q <= flit_type_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            req_addr_q  <= req_addr_d;
            req_src_q   <= req_src_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign network_go_o        = go_q;
    assign network_valid_o     = valid_q;
    assign network_flit_o      = flit_q;
    assign network_flit_type_o = flit_type_q;
    assign network_vc_id_o     = CFG_VC;
    assign filereg_wr_en_o     = wr_en_q;
    assign filereg_rd_en_o     = rd_en_q;
    assign filereg_addr_o      = addr_q;
    assign filereg_wdata_o     = wdata_q;
    assign error_count_o       = err_cnt_q;

endmodule

// File: tb/tb_noc_config_filereg_bridge.sv
// Randomized self-checking bench: packet-level scoreboard predicts strobes,
// response flits and the error counter for each request kind.
module tb_noc_config_filereg_bridge;
    localparam int           OWN  = 3;
    localparam logic [1:0]   T_H  = 2'b00;
    localparam logic [1:0]   T_B  = 2'b01;
    localparam logic [1:0]   T_T  = 2'b10;
    localparam logic [1:0]   T_HT = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nv_i = 1'b0;
    logic [63:0] nf_i = 64'd0;
    logic [1:0]  nt_i = 2'b00;
    logic        nvc_i = 1'b0;
    logic [1:0]  go_i = 2'b01;
    logic [1:0]  go_o, nt_o;
    logic        nv_o, nvc_o, wr_en, rd_en;
    logic [63:0] nf_o;
    logic [7:0]  faddr, errc;
    logic [31:0] wdata;
    logic [31:0] rdata = 32'd0;

    int checks = 0;
    int errors = 0;
    int exp_err = 0;
    bit bp_rand = 1'b0;
    logic [31:0] rd_table [256];
    logic [39:0] wr_seen[$], wr_exp[$];
    logic [7:0]  rd_seen[$], rd_exp[$];
    logic [65:0] rsp_seen[$], rsp_exp[$];
    logic        stall_prev = 1'b0;
    logic [65:0] held_rsp = 66'd0;

    always #5 clk = ~clk;

    noc_config_filereg_bridge #(.NetworkSwitchAddressId(OWN)) dut (
        .clk_network_i(clk), .rst_network_ni(rst_n),
        .network_valid_i(nv_i), .network_flit_i(nf_i), .network_flit_type_i(nt_i),
        .network_vc_id_i(nvc_i), .network_go_o(go_o),
        .network_valid_o(nv_o), .network_flit_o(nf_o), .network_flit_type_o(nt_o),
        .network_vc_id_o(nvc_o), .network_go_i(go_i),
        .filereg_wr_en_o(wr_en), .filereg_rd_en_o(rd_en), .filereg_addr_o(faddr),
        .filereg_wdata_o(wdata), .filereg_rdata_i(rdata), .error_count_o(errc));

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [3:0] dst, input logic [3:0] src,
                                        input logic op, input logic [7:0] addr);
        logic [63:0] f;
        f = 64'd0;
        f[7:0] = addr; f[8] = op; f[12:9] = src; f[16:13] = dst;
        return f;
    endfunction

    // request header with don't-care upper bits filled with noise
    function automatic logic [63:0] req(input logic [3:0] dst, input logic [3:0] src,
                                        input logic op, input logic [7:0] addr);
        logic [63:0] f;
        f = hdr(dst, src, op, addr);
        f[63:17] = 47'({$urandom(), $urandom()});
        return f;
    endfunction

    // File-register model: read data appears exactly one cycle after rd_en
    always @(posedge clk) rdata <= rd_en ? rd_table[faddr] : 32'hBAD0_BAD0;

    // Observe strobes, transferred response flits and stall stability
    always @(negedge clk) begin
        if (stall_prev && rst_n) check_eq("tx_hold_stable", {nv_o, nt_o, nf_o}, {1'b1, held_rsp});
        stall_prev <= rst_n && nv_o && !go_i[0];
        held_rsp   <= {nt_o, nf_o};
        if (rst_n && wr_en) wr_seen.push_back({faddr, wdata});
        if (rst_n && rd_en) rd_seen.push_back(faddr);
        if (rst_n && nv_o && go_i[0]) rsp_seen.push_back({nt_o, nf_o});
    end

    task automatic tick();
        @(posedge clk); #1;
        if (bp_rand) go_i = {1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7)};
    endtask

    task automatic send_flit(input logic [63:0] f, input logic [1:0] t);
        int n;
        n = 0;
        nv_i = 1'b1; nf_i = f; nt_i = t; nvc_i = 1'b0;
        while (go_o[0] !== 1'b1 && n < 100) begin tick(); n++; end
        if (n >= 100) check_eq("accept_timeout", 128'(n), 128'(0));
        tick();
    endtask

    task automatic clear_obs();
        wr_seen.delete(); rd_seen.delete(); rsp_seen.delete();
        wr_exp.delete(); rd_exp.delete(); rsp_exp.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq(tag, {go_o, nv_o, nt_o, nf_o, wr_en, rd_en, faddr, wdata, errc}, 128'd0);
    endtask

    task automatic run_txn(input int kind, input logic [7:0] addr, input logic [31:0] data, input logic [3:0] src);
        int inc, n;
        logic [3:0] bad;
        inc = 0;
        bad = 4'(OWN) ^ 4'($urandom_range(1, 15));
        clear_obs();
        case (kind)
            0: begin
                send_flit(req(4'(OWN), src, 1'b1, addr), T_H);
                send_flit({32'($urandom()), data}, T_T);
                wr_exp.push_back({addr, data});
                rsp_exp.push_back({T_HT, hdr(src, 4'(OWN), 1'b1, addr)});
            end
            1: begin
                send_flit(req(4'(OWN), src, 1'b0, addr), T_HT);
                rd_exp.push_back(addr);
                rsp_exp.push_back({T_H, hdr(src, 4'(OWN), 1'b0, addr)});
                rsp_exp.push_back({T_T, {32'd0, rd_table[addr]}});
            end
            2: begin send_flit(64'($urandom()), T_B); inc = 1; end
            3: begin send_flit(64'($urandom()), T_T); inc = 1; end
            4: begin send_flit(req(4'(OWN), src, 1'b1, addr), T_HT); inc = 1; end
            5: begin
                send_flit(req(4'(OWN), src, 1'b0, addr), T_H);
                send_flit(64'($urandom()), T_B);
                send_flit(64'($urandom()), T_T);
                inc = 1;
            end
            6: begin
                send_flit(req(bad, src, 1'($urandom_range(0, 1)), addr), T_H);
                send_flit(req(4'(OWN), src, 1'b0, addr), T_B);
                send_flit(req(4'(OWN), src, 1'b0, addr), T_T);
                inc = 1;
            end
            7: begin send_flit(req(bad, src, 1'($urandom_range(0, 1)), addr), T_HT); inc = 1; end
            8: begin
                send_flit(req(4'(OWN), src, 1'b1, addr), T_H);
                send_flit(req(4'(OWN), src, 1'b0, addr), T_HT);
                inc = 1;
            end
            default: begin
                send_flit(req(4'(OWN), src, 1'b1, addr), T_H);
                send_flit(64'($urandom()), T_B);
                send_flit(64'($urandom()), T_T);
                inc = 1;
            end
        endcase
        nv_i = 1'b0;
        n = 0;
        while (rsp_seen.size() < rsp_exp.size() && n < 300) begin tick(); n++; end
        repeat (4) tick();
        exp_err = (exp_err + inc > 255) ? 255 : exp_err + inc;
        check_eq("wr_count", 128'(wr_seen.size()), 128'(wr_exp.size()));
        check_eq("rd_count", 128'(rd_seen.size()), 128'(rd_exp.size()));
        check_eq("rsp_count", 128'(rsp_seen.size()), 128'(rsp_exp.size()));
        for (int i = 0; i < wr_exp.size() && i < wr_seen.size(); i++) check_eq("wr_data", wr_seen[i], wr_exp[i]);
        for (int i = 0; i < rd_exp.size() && i < rd_seen.size(); i++) check_eq("rd_addr", rd_seen[i], rd_exp[i]);
        for (int i = 0; i < rsp_exp.size() && i < rsp_seen.size(); i++) check_eq("rsp_flit", rsp_seen[i], rsp_exp[i]);
        check_eq("err_count", errc, 128'(exp_err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) rd_table[i] = $urandom();
        rd_table[5] = 32'h0000_CAFE;

        // reset values
        repeat (3) tick();
        check_zero_outputs("reset_outputs");
        check_eq("reset_vc_id", nvc_o, 128'd0);
        rst_n = 1'b1;
        check_eq("go_before_first_edge", go_o, 128'd0);
        tick();
        check_eq("go_after_reset", go_o, 128'd1);

        // directed write with exact latency
        clear_obs();
        send_flit(req(4'd3, 4'd0, 1'b1, 8'h12), T_H);
        send_flit(64'h0123_4567_DEAD_BEEF, T_T);
        nv_i = 1'b0;
        check_eq("wr_strobe", {wr_en, faddr, wdata}, {1'b1, 8'h12, 32'hDEAD_BEEF});
        check_eq("go_low_busy", go_o, 128'd0);
        tick();
        check_eq("wr_one_cycle", wr_en, 128'd0);
        check_eq("ack_flit", {nv_o, nt_o, nf_o}, {1'b1, T_HT, hdr(4'd0, 4'd3, 1'b1, 8'h12)});
        tick();
        check_eq("ack_done", nv_o, 128'd0);
        check_eq("ack_single", 128'(rsp_seen.size() + wr_seen.size()), 128'd2);

        // directed read with 5+ cycles of back-pressure on the header
        clear_obs();
        go_i = 2'b00;
        send_flit(req(4'd3, 4'd0, 1'b0, 8'h05), T_HT);
        nv_i = 1'b0;
        check_eq("rd_strobe", {rd_en, faddr}, {1'b1, 8'h05});
        tick();
        check_eq("no_early_header", {rd_en, nv_o}, 128'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            check_eq("rd_hdr_held", {nv_o, nt_o, nf_o}, {1'b1, T_H, hdr(4'd0, 4'd3, 1'b0, 8'h05)});
            tick();
        end
        check_eq("rd_hdr_still", {nv_o, nt_o, nf_o}, {1'b1, T_H, hdr(4'd0, 4'd3, 1'b0, 8'h05)});
        go_i = 2'b01;
        tick();
        check_eq("rd_tail", {nv_o, nt_o, nf_o}, {1'b1, T_T, 64'h0000_0000_0000_CAFE});
        tick();
        check_eq("rd_done", nv_o, 128'd0);
        check_eq("rd_no_dup", 128'(rsp_seen.size()), 128'd2);

        // malformed traffic then a good write
        run_txn(2, 8'h00, 32'h0, 4'd0);
        run_txn(4, 8'h44, 32'h0, 4'd0);
        run_txn(6, 8'h45, 32'h0, 4'd0);
        check_eq("malformed_total", errc, 128'd3);
        run_txn(0, 8'h21, 32'h1357_9BDF, 4'd0);

        // off-VC flits never accepted
        clear_obs();
        nv_i = 1'b1; nvc_i = 1'b1; nt_i = T_HT; nf_i = hdr(4'd3, 4'd0, 1'b0, 8'h07);
        for (int k = 0; k < 8; k++) begin
            tick();
            check_eq("offvc_go1", go_o[1], 128'd0);
        end
        nv_i = 1'b0; nvc_i = 1'b0;
        repeat (4) tick();
        check_eq("offvc_no_activity", 128'(rd_seen.size() + wr_seen.size() + rsp_seen.size()), 128'd0);
        check_eq("offvc_err", errc, 128'(exp_err));

        // reset in the middle of a write request
        clear_obs();
        send_flit(req(4'd3, 4'd1, 1'b1, 8'h40), T_H);
        nv_i = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("rst_mid_rx");
        tick();
        rst_n = 1'b1;
        exp_err = 0;
        repeat (2) tick();
        check_eq("rst_rx_no_write", 128'(wr_seen.size()), 128'd0);
        run_txn(3, 8'h00, 32'h0, 4'd0);
        run_txn(1, 8'h77, 32'h0, 4'd2);

        // reset while the read tail is pending
        clear_obs();
        go_i = 2'b00;
        send_flit(req(4'd3, 4'd0, 1'b0, 8'h33), T_HT);
        nv_i = 1'b0;
        n = 0;
        while (nv_o !== 1'b1 && n < 20) begin tick(); n++; end
        check_eq("rst_tx_hdr_seen", nv_o, 128'd1);
        go_i = 2'b01;
        tick();
        go_i = 2'b00;
        check_eq("in_tx_tail", {nv_o, nt_o}, {1'b1, T_T});
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("rst_mid_tx");
        tick();
        rst_n = 1'b1;
        exp_err = 0;
        check_eq("go_low_after_release", go_o, 128'd0);
        go_i = 2'b01;
        tick();
        check_eq("go_high_after_release", go_o, 128'd1);
        repeat (3) tick();
        check_eq("no_tail_after_reset", 128'(rsp_seen.size()), 128'd1);
        run_txn(1, 8'h05, 32'h0, 4'd0);

        // randomized mix with random back-pressure
        bp_rand = 1'b1;
        for (int t = 0; t < 60; t++) begin
            int r, kind;
            r = $urandom_range(0, 15);
            kind = (r < 4) ? 0 : (r < 8) ? 1 : r - 6;
            run_txn(kind, 8'($urandom()), $urandom(), 4'($urandom()));
        end
        bp_rand = 1'b0;
        go_i = 2'b01;

        // error counter saturation
        for (int t = 0; t < 260; t++) run_txn(2, 8'h00, 32'h0, 4'd0);
        check_eq("err_saturated", errc, 128'd255);
        run_txn(0, 8'hA5, 32'h5A5A_0F0F, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/noc_config_filereg_bridge.md
# noc_config_filereg_bridge

Per-tile configuration endpoint on the network side of the NoC configuration path. It consumes configuration request packets ejected from the local port of a tile's NoC router and executes them as single register writes or reads on the router control/status file-register port. For every request it injects a response packet back toward the requesting tile, normally the NoC Controller tile. It is the stage directly downstream of the tile-to-tile mesh fabric that carries configuration traffic.

## Interface
Parameters:
- NetworkSwitchAddressId, 0: this tile's switch id, placed in the response src field.
- NetworkSwitchAddressIdWidth, 4: width of the src and dst id fields.
- NetworkFlitWidth, 64: flit payload width. Must be ≥ FileRegAddrWidth+1+2·IdWidth and ≥ FileRegDataWidth.
- NetworkFlitTypeWidth, 2: flit type encoding: 00 header, 01 body, 10 tail, 11 header_tail.
- NetworkVirtualChannelIdWidth, 1: VC id width.
- NetworkNumberOfVirtualChannels, 2: number of per-VC go bits.
- ConfigVirtualChannel, 0: the only VC used for requests and responses.
- FileRegAddrWidth, 8: register address width.
- FileRegDataWidth, 32: register data width.

Ports:
- clk_network_i  in  1  network clock; all logic is on this clock.
- rst_network_ni  in  1  asynchronous, active-low reset.
- network_valid_i  in  1  request flit valid.
- network_flit_i  in  FlitWidth  request flit payload.
- network_flit_type_i  in  FlitTypeWidth  request flit type.
- network_vc_id_i  in  VcIdWidth  request flit VC.
- network_go_o  out  NumVc  per-VC accept; only bit ConfigVirtualChannel is ever high.
- network_valid_o  out  1  response flit valid.
- network_flit_o  out  FlitWidth  response flit payload.
- network_flit_type_o  out  FlitTypeWidth  response flit type.
- network_vc_id_o  out  VcIdWidth  always ConfigVirtualChannel.
- network_go_i  in  NumVc  downstream accept, per VC.
- filereg_wr_en_o  out  1  one-cycle write strobe.
- filereg_rd_en_o  out  1  one-cycle read strobe.
- filereg_addr_o  out  FileRegAddrWidth  register address.
- filereg_wdata_o  out  FileRegDataWidth  write data.
- filereg_rdata_i  in  FileRegDataWidth  read data, valid exactly 1 cycle after rd_en.
- error_count_o  out  8  saturating count of dropped or malformed packets.

## Operation
- Header fields, LSB first: addr [AW-1:0], op [AW] (1 = write, 0 = read), src [AW+1 +: IdW], dst [AW+1+IdW +: IdW].
- Input accept: a flit is accepted when network_valid_i && network_vc_id_i==ConfigVirtualChannel && network_go_o[ConfigVirtualChannel].
- go is high only in IDLE, RX_DATA and DROP. Flits on other VCs are never accepted.
- Write request: header (op=1) followed by a tail whose flit[DW-1:0] is the write data. Response is a single header_tail ack: dst=req src, src=own id, op=1, addr echoed.
- Read request: a single header_tail (op=0). Response is a header (dst/src/op/addr as for writes) followed by a tail with flit[DW-1:0] = rdata and upper bits 0.
- States:
  - IDLE:
    - header with op=1 → RX_DATA.
    - header_tail with op=0 → REG_READ.
    - header_tail with op=1 → error, stay IDLE.
    - header with op=0 → error, DROP.
    - body or tail → error, stay IDLE.
    - dst ≠ own id → error; DROP if the flit is a header, otherwise stay IDLE.
  - RX_DATA: tail → REG_WRITE; header_tail → error, IDLE; header or body → error, DROP.
  - DROP: accept and discard flits until a tail or header_tail, then IDLE.
  - REG_WRITE: assert wr_en for 1 cycle → TX_ACK.
  - REG_READ: assert rd_en for 1 cycle → READ_WAIT.
  - READ_WAIT: capture rdata into a register → TX_HEADER.
  - TX_ACK / TX_HEADER / TX_TAIL: hold valid_o and the flit stable until network_go_i[ConfigVirtualChannel] is high.
    - TX_ACK → IDLE on transfer.
    - TX_HEADER → TX_TAIL on transfer.
    - TX_TAIL → IDLE on transfer.
- Only one request is in flight at a time; no new request is accepted while a response is pending.
- error_count_o increments by 1 per error event and saturates at 255.

## Timing
- Reset values: all outputs 0, state IDLE, error_count_o 0, network_vc_id_o = ConfigVirtualChannel. network_go_o becomes high the first cycle after reset deasserts.
- Write: tail accepted at cycle T → wr_en/addr/wdata at T+1 → ack valid at T+2 at the earliest.
- Read: header_tail accepted at T → rd_en at T+1 → rdata captured at T+2 → header valid at T+3. The tail is valid the cycle after the header transfers, at the earliest.
- addr_o and wdata_o hold their values until the next request. The strobes are exactly 1 cycle wide.
- A response flit transfers in the same cycle go_i is high; go low only stalls, with no change to the flit.
- Reset asserted mid-operation: immediate return to IDLE. A partial request is discarded, and a pending response is not sent. A strobe in flight is cleared asynchronously.

## Test plan
- Write: id 3, header dst=3 src=0 op=1 addr=0x12, then tail data 0xDEADBEEF → wr_en 1 cycle with addr 0x12 and wdata 0xDEADBEEF; ack header_tail flit dst=0 src=3 op=1 addr=0x12.
- Read: header_tail addr=0x05, filereg returns 0x0000CAFE → header then tail with flit[31:0]=0x0000CAFE, both dst=0.
- Back-pressure: go_i low for 5 cycles during a read response → header held stable; tail follows only after the header transfers; no duplicate flits.
- Malformed traffic: lone body, write header_tail, header with dst≠id followed by body+tail → no strobes; error_count_o=3; the next valid write succeeds.
- Off-VC flits on VC1 → never accepted (go_o[1]=0); no strobes.
- Reset mid-RX_DATA and mid-TX_TAIL → outputs 0, no wr_en, a fresh read completes normally.
